// File: rtl/mult_div_unit_pkg.sv
// Shared opcodes and decode helpers for the multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MADD  = 4'd5;
  localparam logic [3:0] MD_MADDU = 4'd6;
  localparam logic [3:0] MD_MSUB  = 4'd7;
  localparam logic [3:0] MD_MSUBU = 4'd8;
  localparam logic [3:0] MD_MTHI  = 4'd9;
  localparam logic [3:0] MD_MTLO  = 4'd10;

  // Any defined multiply/divide opcode; hazard logic can reuse this.
  function automatic logic is_md(input logic [3:0] op);
    return (op != MD_NONE) && (op <= MD_MTLO);
  endfunction

  // Multiply-class ops (plain, accumulate and subtract).
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || ((op >= MD_MADD) && (op <= MD_MSUBU));
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that treat their operands as two's complement.
  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
module md_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // Load on start, otherwise run one shift/trial-subtract step while iterations remain.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    // Top bit set means the trial subtraction borrowed.
    diff   = rem_sh - {1'b0, dsr_q};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dsr_d = divisor;
      cnt_d = CntW'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  // High during the final iteration; results are valid the cycle after.
  assign done      = (cnt_q == CntW'(1));

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       MDOp,
  input  logic             Flush,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MulCntW = $clog2(MULT_CYCLES + 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDfix} state_e;

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic [MulCntW-1:0]   mcnt_q, mcnt_d;
  logic                 a_neg_q, a_neg_d, q_neg_q, q_neg_d;
  logic                 dzero_q, dzero_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;

  logic                 accept, op_signed, a_neg, b_neg, div_start, div_done;
  logic [WIDTH-1:0]     a_mag, b_mag, div_quo, div_rem, quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod, acc, mul_res;

  assign accept = Start & ~Flush & ~busy_q & is_md(MDOp);

  // Operand conditioning: sign extension for multiply, magnitudes for divide.
  always_comb begin
    op_signed = is_signed_op(MDOp);
    a_neg     = op_signed & SrcA[WIDTH-1];
    b_neg     = op_signed & SrcB[WIDTH-1];
    a_mag     = a_neg ? -SrcA : SrcA;
    b_mag     = b_neg ? -SrcB : SrcB;
    ext_a     = {{WIDTH{a_neg}}, SrcA};
    ext_b     = {{WIDTH{b_neg}}, SrcB};
  end

  // Full product and accumulate against HI/LO as they stand at the accepting edge.
  always_comb begin
    prod = ext_a * ext_b;
    acc  = {hi_q, lo_q};
    case (MDOp)
      MD_MADD, MD_MADDU: mul_res = acc + prod;
      MD_MSUB, MD_MSUBU: mul_res = acc - prod;
      default:           mul_res = prod;
    endcase
  end

  // Restore signs on the unsigned divider result.
  always_comb begin
    quo_fix = q_neg_q ? -div_quo : div_quo;
    rem_fix = a_neg_q ? -div_rem : div_rem;
  end

  md_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Control FSM: issue, multiply countdown, divide iterate and sign-fix commit.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    res_d     = res_q;
    mcnt_d    = mcnt_q;
    a_neg_d   = a_neg_q;
    q_neg_d   = q_neg_q;
    dzero_d   = dzero_q;
    ovf_d     = ovf_q;
    dvd_d     = dvd_q;
    div_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul_op(MDOp)) begin
            state_d = StMul;
            res_d   = mul_res;
            mcnt_d  = MulCntW'(MULT_CYCLES);
          end else if (is_div_op(MDOp)) begin
            state_d   = StDiv;
            div_start = 1'b1;
            a_neg_d   = a_neg;
            q_neg_d   = a_neg ^ b_neg;
            dzero_d   = (SrcB == '0);
            ovf_d     = op_signed && (SrcA == MinNeg) && (SrcB == '1);
            dvd_d     = SrcA;
          end else if (MDOp == MD_MTHI) begin
            hi_d = SrcA;
          end else begin
            lo_d = SrcA;
          end
        end
      end
      StMul: begin
        if (mcnt_q == MulCntW'(1)) begin
          {hi_d, lo_d} = res_q;
          mcnt_d       = '0;
          state_d      = StIdle;
        end else begin
          mcnt_d = mcnt_q - MulCntW'(1);
        end
      end
      StDiv: begin
        if (div_done) begin
          state_d = StDfix;
        end
      end
      StDfix: begin
        state_d = StIdle;
        if (dzero_q) begin
          lo_d = '1;
          hi_d = dvd_q;
        end else if (ovf_q) begin
          lo_d = MinNeg;
          hi_d = '0;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and architectural registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      mcnt_q  <= '0;
      a_neg_q <= 1'b0;
      q_neg_q <= 1'b0;
      dzero_q <= 1'b0;
      ovf_q   <= 1'b0;
      dvd_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      mcnt_q  <= mcnt_d;
      a_neg_q <= a_neg_d;
      q_neg_q <= q_neg_d;
      dzero_q <= dzero_d;
      ovf_q   <= ovf_d;
      dvd_q   <= dvd_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench: vector table plus hand-written issue/reset sequences.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  MDOp = 4'd0;
  logic        Flush = 1'b0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  mult_div_unit #(
    .WIDTH       (32),
    .MULT_CYCLES (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .Flush (Flush),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts edges until Busy drops; a blown budget is a failure.
  task automatic wait_idle(input string name, output int lat);
    lat = 0;
    while (Busy !== 1'b0 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (Busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s: Busy stuck, got %b expected 0", name, Busy);
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got HI=%h LO=%h expected an entry", name, HI, LO);
    end else begin
      e = sb_q.pop_front();
      check32({name, "_hi"}, HI, e.hi);
      check32({name, "_lo"}, LO, e.lo);
    end
  endtask

  // Issue one op from the idle state, wait for completion and score it.
  task automatic run_vec(input vec_t v);
    int lat;
    sb_q.push_back('{v.hi, v.lo});
    Start = 1'b1;
    MDOp  = v.op;
    SrcA  = v.a;
    SrcB  = v.b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    wait_idle(v.name, lat);
    check_int({v.name, "_lat"}, lat, v.lat);
    pop_check(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;

    vecs.push_back('{"mult_max",   MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5});
    vecs.push_back('{"mult_neg",   MD_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5});
    vecs.push_back('{"multu",      MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5});
    vecs.push_back('{"div_neg",    MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33});
    vecs.push_back('{"divu_zero",  MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 33});
    vecs.push_back('{"div_ovf",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33});
    vecs.push_back('{"mthi",       MD_MTHI,  32'h00000000, 32'h12345678, 32'h00000000, 32'h80000000, 0});
    vecs.push_back('{"mtlo",       MD_MTLO,  32'hFFFFFFFF, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 0});
    vecs.push_back('{"maddu",      MD_MADDU, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, 5});
    vecs.push_back('{"msub",       MD_MSUB,  32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 5});
    vecs.push_back('{"divu",       MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33});
    vecs.push_back('{"div_negdvs", MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33});
    vecs.push_back('{"div_zero",   MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 33});
    vecs.push_back('{"multu_max",  MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5});
    vecs.push_back('{"madd_neg",   MD_MADD,  32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, 32'hFFFFFFFE, 5});
    vecs.push_back('{"msubu",      MD_MSUBU, 32'h00000002, 32'h00000003, 32'hFFFFFFFD, 32'hFFFFFFF8, 5});
    vecs.push_back('{"div_min2",   MD_DIV,   32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000, 33});
    vecs.push_back('{"op_none",    MD_NONE,  32'h11111111, 32'h22222222, 32'h00000000, 32'hC0000000, 0});
    vecs.push_back('{"op_undef",   4'hF,     32'h11111111, 32'h22222222, 32'h00000000, 32'hC0000000, 0});

    // Reset state.
    #22;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check32("rst_busy", {31'd0, Busy}, 32'd0);
    check32("rst_hi", HI, 32'd0);
    check32("rst_lo", LO, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // DIV presented while busy must be dropped.
    sb_q.push_back('{32'd0, 32'd15});
    Start = 1'b1; MDOp = MD_MULTU; SrcA = 32'd3; SrcB = 32'd5;
    @(posedge clk);
    #1;
    MDOp = MD_DIV; SrcA = 32'd100; SrcB = 32'd0;
    @(posedge clk);
    #1;
    Start = 1'b0;
    wait_idle("busy_ignore", lat);
    check_int("busy_ignore_lat", lat, 4);
    pop_check("busy_ignore");
    @(posedge clk);
    #1;
    check32("busy_ignore_idle", {31'd0, Busy}, 32'd0);
    check32("busy_ignore_lo2", LO, 32'd15);

    // Flush squashes same-cycle requests.
    Start = 1'b1; Flush = 1'b1; MDOp = MD_MTHI; SrcA = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    check32("flush_mthi_hi", HI, 32'd0);
    MDOp = MD_MULT; SrcA = 32'd9; SrcB = 32'd9;
    @(posedge clk);
    #1;
    Start = 1'b0; Flush = 1'b0;
    check32("flush_busy", {31'd0, Busy}, 32'd0);
    check32("flush_lo", LO, 32'd15);

    // Back-to-back: second MULT held across the completion edge, taken once Busy is low.
    sb_q.push_back('{32'd0, 32'd6});
    Start = 1'b1; MDOp = MD_MULT; SrcA = 32'd2; SrcB = 32'd3;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check32("b2b_busy_mid", {31'd0, Busy}, 32'd1);
    sb_q.push_back('{32'd0, 32'd20});
    Start = 1'b1; MDOp = MD_MULT; SrcA = 32'd4; SrcB = 32'd5;
    @(posedge clk);
    #1;
    check32("b2b_first_done", {31'd0, Busy}, 32'd0);
    pop_check("b2b_first");
    @(posedge clk);
    #1;
    Start = 1'b0;
    check32("b2b_second_busy", {31'd0, Busy}, 32'd1);
    wait_idle("b2b_second", lat);
    check_int("b2b_second_lat", lat, 5);
    pop_check("b2b_second");

    // Asynchronous reset in the middle of a divide.
    Start = 1'b1; MDOp = MD_DIV; SrcA = 32'd100; SrcB = 32'd3;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check32("mid_rst_busy", {31'd0, Busy}, 32'd0);
    check32("mid_rst_hi", HI, 32'd0);
    check32("mid_rst_lo", LO, 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check32("post_rst_idle", {31'd0, Busy}, 32'd0);
    run_vec('{"post_rst_multu", MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 5});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
